// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle: WB and AUX request channels plus the
// arbitrated write port and status outputs.
interface rf_write_arbiter_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_valid;
  logic          wb_ready;
  logic [3:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          aux_valid;
  logic          aux_ready;
  logic [3:0]    aux_addr;
  logic [31:0]   aux_data;
  logic [3:0]    rf_c;
  logic [31:0]   rf_pw;
  logic          rf_ld;
  logic          r15_wr;
  logic          stall;
  logic [CW-1:0] pending;

  modport master (
    output wb_valid, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
    input  wb_ready, aux_ready, rf_c, rf_pw, rf_ld, r15_wr, stall, pending
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
    output wb_ready, aux_ready, rf_c, rf_pw, rf_ld, r15_wr, stall, pending
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage (priority)
// and a small FIFO of AUX base-register updates, with an age-forced drain.
module rf_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input logic               CLK,
  input logic               RST,
  rf_write_arbiter_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic [3:0]      r_addr [DEPTH];
  logic [31:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AGE_W-1:0] r_age;
  logic [AGE_W-1:0] w_age_next;
  logic            r_rf_ld;
  logic [3:0]      r_rf_c;
  logic [31:0]     r_rf_pw;

  logic [AW:0]     w_count;
  logic [AW-1:0]   w_head_idx;
  logic            w_empty;
  logic            w_full;
  logic            w_enq;
  logic            w_pop;
  logic            w_wb_grant;
  logic            w_head_live;
  logic            w_head_kill;
  logic            w_head_wait;
  logic            w_ld_next;
  logic [3:0]      w_c_next;
  logic [31:0]     w_pw_next;
  logic [DEPTH-1:0] w_live_next;
  logic [3:0]      w_addr_next [DEPTH];
  logic [31:0]     w_data_next [DEPTH];

  // Pointers carry a wrap bit, so a full FIFO shows up as the count's top bit.
  assign w_count     = r_wptr - r_rptr;
  assign w_empty     = (w_count == '0);
  assign w_full      = w_count[AW];
  assign w_head_idx  = r_rptr[AW-1:0];
  assign w_wb_grant  = (r_state == ST_NORMAL) && bus.wb_valid;
  assign w_enq       = bus.aux_valid && !w_full;
  assign w_head_live = !w_empty && r_live[w_head_idx];
  assign w_head_kill = w_wb_grant && (r_addr[w_head_idx] == bus.wb_addr);
  // A head killed by this WB grant no longer needs draining, so it stops aging.
  assign w_head_wait = w_wb_grant && w_head_live && !w_head_kill;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic w_wr_sel;
      assign w_wr_sel = w_enq && (r_wptr[AW-1:0] == AW'(gi));
      // WB is younger than any queued or same-edge AUX write to its register.
      assign w_live_next[gi] = w_wr_sel
          ? !(w_wb_grant && (bus.aux_addr == bus.wb_addr))
          : (r_live[gi] && !(w_wb_grant && (r_addr[gi] == bus.wb_addr)));
      assign w_addr_next[gi] = w_wr_sel ? bus.aux_addr : r_addr[gi];
      assign w_data_next[gi] = w_wr_sel ? bus.aux_data : r_data[gi];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_ld_next    = 1'b0;
    w_c_next     = r_rf_c;
    w_pw_next    = r_rf_pw;
    case (r_state)
      ST_NORMAL: begin
        if (w_wb_grant) begin
          w_ld_next = 1'b1;
          w_c_next  = bus.wb_addr;
          w_pw_next = bus.wb_data;
          if (w_head_wait && (r_age == AGE_MAX)) begin
            w_state_next = ST_FORCE;
          end
        end else if (!w_empty) begin
          w_pop     = 1'b1;
          w_ld_next = w_head_live;
          if (w_head_live) begin
            w_c_next  = r_addr[w_head_idx];
            w_pw_next = r_data[w_head_idx];
          end
        end
      end
      ST_FORCE: begin
        w_state_next = ST_NORMAL;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_ld_next = w_head_live;
          if (w_head_live) begin
            w_c_next  = r_addr[w_head_idx];
            w_pw_next = r_data[w_head_idx];
          end
        end
      end
      default: w_state_next = ST_NORMAL;
    endcase
  end

  always_comb begin
    w_age_next = '0;
    if (w_head_wait) begin
      w_age_next = (r_age == AGE_MAX) ? r_age : r_age + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_NORMAL;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_age   <= '0;
      r_live  <= '0;
      r_rf_ld <= 1'b0;
      r_rf_c  <= '0;
      r_rf_pw <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_age   <= w_age_next;
      r_live  <= w_live_next;
      r_rf_ld <= w_ld_next;
      r_rf_c  <= w_c_next;
      r_rf_pw <= w_pw_next;
      if (w_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= w_addr_next[i];
        r_data[i] <= w_data_next[i];
      end
    end
  end

  assign bus.wb_ready  = (r_state == ST_NORMAL);
  assign bus.stall     = (r_state != ST_NORMAL);
  assign bus.aux_ready = !w_full;
  assign bus.rf_ld     = r_rf_ld;
  assign bus.rf_c      = r_rf_c;
  assign bus.rf_pw     = r_rf_pw;
  assign bus.r15_wr    = r_rf_ld && (r_rf_c == 4'hF);
  assign bus.pending   = w_count;
endmodule
